mem_resp_stage: RTL

MEM_RESP_STAGE -- requirements
Module: mem_resp_stage

---
 rtl/mem_resp_stage_pkg.sv | 27 ++
 rtl/mem_ld_extract.sv | 32 +++
 rtl/mem_resp_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mem_resp_stage_pkg.sv
// rtl/mem_resp_stage_pkg.sv - load-type encoding and in-flight entry record shared by the memory response stage
package mem_resp_stage_pkg;

  localparam int ME_MAX_W = 64;

  localparam logic [2:0] LD_B  = 3'd0;
  localparam logic [2:0] LD_BU = 3'd1;
  localparam logic [2:0] LD_H  = 3'd2;
  localparam logic [2:0] LD_HU = 3'd3;
  localparam logic [2:0] LD_W  = 3'd4;
  localparam logic [2:0] LD_D  = 3'd5;

  // pc/result sized for the widest build; narrower builds use the low DATA_W bits
  typedef struct packed {
    logic [ME_MAX_W-1:0] pc;
    logic [ME_MAX_W-1:0] result;
    logic [2:0]          ld_type;
    logic [4:0]          dest;
    logic                gr_we;
    logic                excp;
    logic                is_load;
    logic                is_mem;
    logic                waiting;
    logic                done;
  } me_entry_t;

endpackage

// File: rtl/mem_ld_extract.sv
// rtl/mem_ld_extract.sv - selects byte/half/word/dword from a memory response and zero/sign-extends it
module mem_ld_extract
  import mem_resp_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        offset,
  input  logic [2:0]        ld_type,
  output logic [DATA_W-1:0] data
);

  logic [2:0]        off;
  logic [DATA_W-1:0] shifted;

  // a 32-bit bus only has four byte lanes, so the top offset bit is ignored there
  assign off     = (DATA_W == 64) ? offset : {1'b0, offset[1:0]};
  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    data = shifted;
    case (ld_type)
      LD_B:    data = DATA_W'($signed(shifted[7:0]));
      LD_BU:   data = DATA_W'(shifted[7:0]);
      LD_H:    data = DATA_W'($signed(shifted[15:0]));
      LD_HU:   data = DATA_W'(shifted[15:0]);
      LD_W:    data = DATA_W'($signed(shifted[31:0]));
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_resp_stage.sv
// rtl/mem_resp_stage.sv - in-order ME stage FIFO matching memory responses to issued loads/stores
// Optional head-entry bypass enabled by defining ME_HEAD_FWD_EN.
module mem_resp_stage
  import mem_resp_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_ld_type,
  input  logic              in_gr_we,
  input  logic [4:0]        in_dest,
  input  logic              in_excp,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_result,
  output logic              out_gr_we,
  output logic [4:0]        out_dest,
  output logic              out_excp,
  output logic [31:0]       dest_busy,
  output logic              fwd_valid,
  output logic [4:0]        fwd_dest,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  me_entry_t         ent [DEPTH];
  me_entry_t         new_e;
  logic [DEPTH-1:0]  valid;
  logic [PW-1:0]     head, tail, wait_idx, scan_idx;
  logic [CW-1:0]     count, drop_cnt, n_waiting;
  logic              push, pop, resp_hit, drop_dec, wait_found;
  logic [DATA_W-1:0] ld_data;

  assign in_ready  = (count < CW'(DEPTH)) && !flush;
  assign out_valid = valid[head] && ent[head].done && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  // pending drops absorb responses before any live entry can claim one
  assign drop_dec  = data_ok && (drop_cnt != '0);
  assign resp_hit  = data_ok && (drop_cnt == '0) && wait_found;

  always_comb begin
    wait_found = 1'b0;
    wait_idx   = '0;
    scan_idx   = '0;
    n_waiting  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PW'(i);
      if (!wait_found && valid[scan_idx] && ent[scan_idx].is_mem && ent[scan_idx].waiting) begin
        wait_found = 1'b1;
        wait_idx   = scan_idx;
      end
      n_waiting = n_waiting + CW'(valid[i] && ent[i].waiting);
    end
  end

  always_comb begin
    new_e         = '0;
    new_e.pc      = ME_MAX_W'(in_pc);
    new_e.result  = ME_MAX_W'(in_result);
    new_e.ld_type = in_ld_type;
    new_e.dest    = in_dest;
    new_e.gr_we   = in_gr_we;
    new_e.excp    = in_excp;
    new_e.is_load = in_is_load;
    new_e.is_mem  = in_is_load || in_is_store;
    new_e.waiting = (in_is_load || in_is_store) && !in_excp;
    new_e.done    = !((in_is_load || in_is_store) && !in_excp);
  end

  mem_ld_extract #(.DATA_W(DATA_W)) u_ld_extract (
    .rdata   (rdata),
    .offset  (ent[wait_idx].result[2:0]),
    .ld_type (ent[wait_idx].ld_type),
    .data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      valid    <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      drop_cnt <= drop_cnt - CW'(drop_dec) + n_waiting - CW'(resp_hit);
    end else begin
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      if (drop_dec) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // payload needs no reset: valid bits gate every use
  always_ff @(posedge clk) begin
    if (push) ent[tail] <= new_e;
    if (resp_hit) begin
      ent[wait_idx].waiting <= 1'b0;
      ent[wait_idx].done    <= 1'b1;
      if (ent[wait_idx].is_load) ent[wait_idx].result <= ME_MAX_W'(ld_data);
    end
  end

  assign out_pc     = out_valid ? DATA_W'(ent[head].pc) : '0;
  assign out_result = out_valid ? DATA_W'(ent[head].result) : '0;
  assign out_gr_we  = out_valid ? ent[head].gr_we : 1'b0;
  assign out_dest   = out_valid ? ent[head].dest : 5'd0;
  assign out_excp   = out_valid ? ent[head].excp : 1'b0;

  always_comb begin
    dest_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && ent[i].gr_we) dest_busy[ent[i].dest] = 1'b1;
    end
    dest_busy[0] = 1'b0;
  end

`ifdef ME_HEAD_FWD_EN
  assign fwd_valid = out_valid && out_gr_we && !out_excp;
  assign fwd_dest  = fwd_valid ? out_dest : 5'd0;
  assign fwd_data  = fwd_valid ? out_result : '0;
`else
  assign fwd_valid = 1'b0;
  assign fwd_dest  = 5'd0;
  assign fwd_data  = '0;
`endif

endmodule
